control_unit: RTL and testbench

- Hardwired sequencer that drives every control input of the ALU_System datapath (mux selects, RF/ARF/IR/ALU/memory controls).
- Consumes the 16-bit IR contents and the ALU ZCNO flags.
- Runs a fixed fetch-low / fetch-high / execute (+ optional memory) cycle per instruction.
- Sits beside the datapath in the CPU top; the top exports IR_out and ALU_ZCNO to it.

---
 rtl/cu_pkg.sv | 99 +++++++++
 rtl/control_unit_if.sv | 45 ++++
 rtl/cu_decode.sv | 128 ++++++++++++
 rtl/control_unit.sv | 61 ++++++
 tb/tb_control_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared codes for the control unit.
//   - state_t  : sequencer states (code driven onto the State output)
//   - OP_*     : 4-bit instruction opcodes found in IR[15:12]
//   - MUX_*    : datapath mux encodings (MuxA/MuxB share one, MuxC has its own)
//   - ARF_*    : address-register-file select codes and enable masks
//   - FUN_*, IR_LOAD, ALU_* : function codes for RF/ARF, IR and ALU
//   - ctrl_t   : the full control vector driven into the datapath
//   - helpers  : idle_ctrl(), rf_sel(), rf_en()
package cu_pkg;

  typedef enum logic [2:0] {
    FETCH_L = 3'd0,
    FETCH_H = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_LDM = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_MOV = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_BRA = 4'h8;
  localparam logic [3:0] OP_BNE = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  // MuxA / MuxB source encodings
  localparam logic [1:0] MUX_ALU = 2'd0;
  localparam logic [1:0] MUX_MEM = 2'd1;
  localparam logic [1:0] MUX_IMM = 2'd2;
  localparam logic [1:0] MUX_ARF = 2'd3;

  // MuxC source encodings
  localparam logic MUXC_RF  = 1'b0;
  localparam logic MUXC_ARF = 1'b1;

  // ARF output-select codes and load-enable masks
  localparam logic [1:0] ARF_PC    = 2'b00;
  localparam logic [1:0] ARF_AR    = 2'b01;
  localparam logic [1:0] ARF_SP    = 2'b10;
  localparam logic [3:0] ARF_EN_PC = 4'b0001;
  localparam logic [3:0] ARF_EN_AR = 4'b0010;
  localparam logic [3:0] ARF_EN_SP = 4'b0100;

  // Function codes
  localparam logic [1:0] FUN_LOAD  = 2'b01;
  localparam logic [1:0] FUN_INC   = 2'b11;
  localparam logic [1:0] IR_LOAD   = 2'b01;
  localparam logic [3:0] ALU_PASSA = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;

  typedef struct packed {
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
    logic [2:0] rf_outa_sel;
    logic [2:0] rf_outb_sel;
    logic [1:0] rf_funsel;
    logic [3:0] rf_tsel;
    logic [3:0] rf_rsel;
    logic [3:0] alu_funsel;
    logic [1:0] arf_outa_sel;
    logic [1:0] arf_outb_sel;
    logic [1:0] arf_funsel;
    logic [3:0] arf_rsel;
    logic [1:0] ir_funsel;
    logic       ir_enable;
    logic       ir_lh;
    logic       mem_wr;
    logic       mem_cs;
    logic       halted;
  } ctrl_t;

  // Nothing enabled, memory deselected (chip select is active-low).
  function automatic ctrl_t idle_ctrl();
    ctrl_t c;
    c        = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  // Rd/Rs field to RF output-select code
  function automatic logic [2:0] rf_sel(input logic [1:0] n);
    return {1'b0, n};
  endfunction

  // Rd field to one-hot RF load enable
  function automatic logic [3:0] rf_en(input logic [1:0] n);
    return 4'b0001 << n;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: bundle between the control unit and the ALU_System datapath.
//   IR, ZCNO             : datapath -> control unit (instruction word, ALU flags)
//   Mux*/RF_*/ALU_*/ARF_*/IR_*/Mem_* : control unit -> datapath
//   State, Halted        : sequencer status
// master = control unit side, slave = datapath side.
interface control_unit_if;
  logic [15:0] IR;
  logic [3:0]  ZCNO;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        MuxCSel;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_TSel;
  logic [3:0]  RF_RSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  ARF_OutASel;
  logic [1:0]  ARF_OutBSel;
  logic [1:0]  ARF_FunSel;
  logic [3:0]  ARF_RSel;
  logic [1:0]  IR_Funsel;
  logic        IR_Enable;
  logic        IR_LH;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [2:0]  State;
  logic        Halted;

  modport master (
    input  IR, ZCNO,
    output MuxASel, MuxBSel, MuxCSel, RF_OutASel, RF_OutBSel, RF_FunSel,
           RF_TSel, RF_RSel, ALU_FunSel, ARF_OutASel, ARF_OutBSel,
           ARF_FunSel, ARF_RSel, IR_Funsel, IR_Enable, IR_LH, Mem_WR,
           Mem_CS, State, Halted
  );

  modport slave (
    output IR, ZCNO,
    input  MuxASel, MuxBSel, MuxCSel, RF_OutASel, RF_OutBSel, RF_FunSel,
           RF_TSel, RF_RSel, ALU_FunSel, ARF_OutASel, ARF_OutBSel,
           ARF_FunSel, ARF_RSel, IR_Funsel, IR_Enable, IR_LH, Mem_WR,
           Mem_CS, State, Halted
  );
endinterface

// File: rtl/cu_decode.sv
// cu_decode: purely combinational decoder.
//   state      in  current sequencer state
//   ir         in  instruction word ([15:12] opcode, [11:10] Rd, [9:8] Rs)
//   zcno       in  ALU flags, Z = zcno[3]
//   ctrl       out control vector for the datapath
//   state_next out state to enter on the next clock
module cu_decode
  import cu_pkg::*;
(
  input  state_t      state,
  input  logic [15:0] ir,
  input  logic [3:0]  zcno,
  output ctrl_t       ctrl,
  output state_t      state_next
);

  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       unused_bits;

  assign opcode = ir[15:12];
  assign rd     = ir[11:10];
  assign rs     = ir[9:8];

  // The immediate is routed by the datapath itself; only Z matters here.
  assign unused_bits = ^{ir[7:0], zcno[2:0]};

  always_comb begin
    ctrl       = idle_ctrl();
    state_next = FETCH_L;

    case (state)
      FETCH_L, FETCH_H: begin
        // Read mem[PC] into one IR half and bump PC in the same cycle.
        ctrl.arf_outb_sel = ARF_PC;
        ctrl.mem_cs       = 1'b0;
        ctrl.mem_wr       = 1'b0;
        ctrl.ir_enable    = 1'b1;
        ctrl.ir_lh        = (state == FETCH_H);
        ctrl.ir_funsel    = IR_LOAD;
        ctrl.arf_rsel     = ARF_EN_PC;
        ctrl.arf_funsel   = FUN_INC;
        state_next        = (state == FETCH_L) ? FETCH_H : EXEC;
      end

      EXEC: begin
        case (opcode)
          OP_LDI: begin
            ctrl.mux_a_sel = MUX_IMM;
            ctrl.rf_funsel = FUN_LOAD;
            ctrl.rf_rsel   = rf_en(rd);
          end
          OP_LDM, OP_ST: begin
            // Latch the address into AR; the access itself happens in MEM.
            ctrl.mux_b_sel  = MUX_IMM;
            ctrl.arf_funsel = FUN_LOAD;
            ctrl.arf_rsel   = ARF_EN_AR;
            state_next      = MEM;
          end
          OP_MOV: begin
            ctrl.rf_outa_sel = rf_sel(rs);
            ctrl.mux_c_sel   = MUXC_RF;
            ctrl.alu_funsel  = ALU_PASSA;
            ctrl.mux_a_sel   = MUX_ALU;
            ctrl.rf_funsel   = FUN_LOAD;
            ctrl.rf_rsel     = rf_en(rd);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctrl.rf_outa_sel = rf_sel(rd);
            ctrl.rf_outb_sel = rf_sel(rs);
            ctrl.mux_c_sel   = MUXC_RF;
            case (opcode)
              OP_ADD:  ctrl.alu_funsel = ALU_ADD;
              OP_SUB:  ctrl.alu_funsel = ALU_SUB;
              OP_AND:  ctrl.alu_funsel = ALU_AND;
              default: ctrl.alu_funsel = ALU_OR;
            endcase
            ctrl.mux_a_sel = MUX_ALU;
            ctrl.rf_funsel = FUN_LOAD;
            ctrl.rf_rsel   = rf_en(rd);
          end
          OP_BRA, OP_BNE: begin
            // Flags still hold the result of the previous ALU instruction.
            if (opcode == OP_BRA || !zcno[3]) begin
              ctrl.mux_b_sel  = MUX_IMM;
              ctrl.arf_funsel = FUN_LOAD;
              ctrl.arf_rsel   = ARF_EN_PC;
            end
          end
          OP_HLT: begin
            state_next = HALT;
          end
          default: begin
            // Unassigned opcodes behave as NOP.
          end
        endcase
      end

      MEM: begin
        ctrl.arf_outb_sel = ARF_AR;
        ctrl.mem_cs       = 1'b0;
        if (opcode == OP_LDM) begin
          ctrl.mem_wr    = 1'b0;
          ctrl.mux_a_sel = MUX_MEM;
          ctrl.rf_funsel = FUN_LOAD;
          ctrl.rf_rsel   = rf_en(rd);
        end else begin
          // Store: Rs travels RF -> MuxC -> ALU pass-through -> memory data.
          ctrl.rf_outa_sel = rf_sel(rs);
          ctrl.mux_c_sel   = MUXC_RF;
          ctrl.alu_funsel  = ALU_PASSA;
          ctrl.mem_wr      = 1'b1;
        end
      end

      HALT: begin
        ctrl.halted = 1'b1;
        state_next  = HALT;
      end

      default: begin
        // Unreachable codes recover into a fresh fetch.
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch-low / fetch-high / execute (/ memory)
// sequencer for the ALU_System datapath.
//   Clock  in  rising-edge clock
//   Reset  in  asynchronous, active-high; forces FETCH_L and idle outputs
//   bus    master side of control_unit_if (IR/ZCNO in, all controls out)
// Outputs are combinational from state, IR and flags; only the state is stored.
module control_unit
  import cu_pkg::*;
(
  input  logic           Clock,
  input  logic           Reset,
  control_unit_if.master bus
);

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl_dec;
  ctrl_t  ctrl_out;

  cu_decode u_decode (
    .state      (state_reg),
    .ir         (bus.IR),
    .zcno       (bus.ZCNO),
    .ctrl       (ctrl_dec),
    .state_next (state_next)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_reg <= FETCH_L;
    else       state_reg <= state_next;
  end

  // Hold the datapath quiet for the whole time Reset is high, not just
  // until the next edge, so no stray fetch happens during reset.
  always_comb begin
    ctrl_out = ctrl_dec;
    if (Reset) ctrl_out = idle_ctrl();
  end

  assign bus.MuxASel     = ctrl_out.mux_a_sel;
  assign bus.MuxBSel     = ctrl_out.mux_b_sel;
  assign bus.MuxCSel     = ctrl_out.mux_c_sel;
  assign bus.RF_OutASel  = ctrl_out.rf_outa_sel;
  assign bus.RF_OutBSel  = ctrl_out.rf_outb_sel;
  assign bus.RF_FunSel   = ctrl_out.rf_funsel;
  assign bus.RF_TSel     = ctrl_out.rf_tsel;
  assign bus.RF_RSel     = ctrl_out.rf_rsel;
  assign bus.ALU_FunSel  = ctrl_out.alu_funsel;
  assign bus.ARF_OutASel = ctrl_out.arf_outa_sel;
  assign bus.ARF_OutBSel = ctrl_out.arf_outb_sel;
  assign bus.ARF_FunSel  = ctrl_out.arf_funsel;
  assign bus.ARF_RSel    = ctrl_out.arf_rsel;
  assign bus.IR_Funsel   = ctrl_out.ir_funsel;
  assign bus.IR_Enable   = ctrl_out.ir_enable;
  assign bus.IR_LH       = ctrl_out.ir_lh;
  assign bus.Mem_WR      = ctrl_out.mem_wr;
  assign bus.Mem_CS      = ctrl_out.mem_cs;
  assign bus.Halted      = ctrl_out.halted;
  assign bus.State       = state_reg;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed, table-driven bench for control_unit.
// The bench plays the datapath: it drives IR/ZCNO and checks every control
// output in each state of each instruction against hand-built expectations.
module tb_control_unit;

  logic clk;
  logic rst;

  control_unit_if cu_if ();

  control_unit dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (cu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic [2:0] outa;
    logic [2:0] outb;
    logic [1:0] rf_fun;
    logic [3:0] rf_tsel;
    logic [3:0] rf_rsel;
    logic [3:0] alu;
    logic [1:0] arf_outa;
    logic [1:0] arf_outb;
    logic [1:0] arf_fun;
    logic [3:0] arf_rsel;
    logic [1:0] ir_fun;
    logic       ir_en;
    logic       ir_lh;
    logic       mem_wr;
    logic       mem_cs;
    logic       halted;
  } tb_ctrl_t;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  zcno;
    tb_ctrl_t    exp_exec;
    logic        has_mem;
    tb_ctrl_t    exp_mem;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic tb_ctrl_t idle_v();
    tb_ctrl_t c;
    c        = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  function automatic tb_ctrl_t fetch_v(input logic lh);
    tb_ctrl_t c;
    c          = idle_v();
    c.arf_outb = 2'b00;
    c.mem_cs   = 1'b0;
    c.ir_en    = 1'b1;
    c.ir_lh    = lh;
    c.ir_fun   = 2'b01;
    c.arf_rsel = 4'b0001;
    c.arf_fun  = 2'b11;
    return c;
  endfunction

  function automatic tb_ctrl_t sample();
    tb_ctrl_t s;
    s.mux_a    = cu_if.MuxASel;
    s.mux_b    = cu_if.MuxBSel;
    s.mux_c    = cu_if.MuxCSel;
    s.outa     = cu_if.RF_OutASel;
    s.outb     = cu_if.RF_OutBSel;
    s.rf_fun   = cu_if.RF_FunSel;
    s.rf_tsel  = cu_if.RF_TSel;
    s.rf_rsel  = cu_if.RF_RSel;
    s.alu      = cu_if.ALU_FunSel;
    s.arf_outa = cu_if.ARF_OutASel;
    s.arf_outb = cu_if.ARF_OutBSel;
    s.arf_fun  = cu_if.ARF_FunSel;
    s.arf_rsel = cu_if.ARF_RSel;
    s.ir_fun   = cu_if.IR_Funsel;
    s.ir_en    = cu_if.IR_Enable;
    s.ir_lh    = cu_if.IR_LH;
    s.mem_wr   = cu_if.Mem_WR;
    s.mem_cs   = cu_if.Mem_CS;
    s.halted   = cu_if.Halted;
    return s;
  endfunction

  task automatic chk_ctrl(input string name, input tb_ctrl_t exp);
    tb_ctrl_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: controls got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [2:0] exp);
    checks++;
    if (cu_if.State !== exp) begin
      errors++;
      $display("FAIL %s: State got %0d expected %0d", name, cu_if.State, exp);
    end
  endtask

  task automatic add(input logic [15:0] ir, input logic [3:0] zcno,
                     input tb_ctrl_t e, input logic has_mem, input tb_ctrl_t m);
    vec_t v;
    v.ir       = ir;
    v.zcno     = zcno;
    v.exp_exec = e;
    v.has_mem  = has_mem;
    v.exp_mem  = m;
    vq.push_back(v);
  endtask

  // Entered mid-cycle while in FETCH_L; leaves mid-cycle back in FETCH_L.
  task automatic run_instr(input vec_t v);
    chk_state("fetch_l_state", 3'd0);
    chk_ctrl("fetch_l_ctrl", fetch_v(1'b0));
    cu_if.IR   = v.ir;
    cu_if.ZCNO = v.zcno;
    @(posedge clk); #2;
    chk_state("fetch_h_state", 3'd1);
    chk_ctrl("fetch_h_ctrl", fetch_v(1'b1));
    @(posedge clk); #2;
    chk_state("exec_state", 3'd2);
    chk_ctrl("exec_ctrl", v.exp_exec);
    @(posedge clk); #2;
    if (v.has_mem) begin
      chk_state("mem_state", 3'd3);
      chk_ctrl("mem_ctrl", v.exp_mem);
      @(posedge clk); #2;
    end
    $display("instr ir=%h zcno=%b mem=%0d checks=%0d errors=%0d",
             v.ir, v.zcno, v.has_mem, checks, errors);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_ctrl_t e;
    tb_ctrl_t m;
    vec_t     v;

    // ---------------- vector table ----------------
    // LDI R1,0x2A
    e = idle_v(); e.mux_a = 2'd2; e.rf_fun = 2'b01; e.rf_rsel = 4'b0010;
    add(16'h042A, 4'h0, e, 1'b0, idle_v());
    // ADD R0,R3
    e = idle_v(); e.outa = 3'b000; e.outb = 3'b011; e.alu = 4'b0100;
    e.rf_fun = 2'b01; e.rf_rsel = 4'b0001;
    add(16'h4300, 4'h0, e, 1'b0, idle_v());
    // SUB R2,R1
    e = idle_v(); e.outa = 3'b010; e.outb = 3'b001; e.alu = 4'b0110;
    e.rf_fun = 2'b01; e.rf_rsel = 4'b0100;
    add(16'h5900, 4'h0, e, 1'b0, idle_v());
    // AND R3,R0
    e = idle_v(); e.outa = 3'b011; e.outb = 3'b000; e.alu = 4'b0111;
    e.rf_fun = 2'b01; e.rf_rsel = 4'b1000;
    add(16'h6C00, 4'h0, e, 1'b0, idle_v());
    // OR R1,R2
    e = idle_v(); e.outa = 3'b001; e.outb = 3'b010; e.alu = 4'b1000;
    e.rf_fun = 2'b01; e.rf_rsel = 4'b0010;
    add(16'h7600, 4'h0, e, 1'b0, idle_v());
    // MOV R3,R1
    e = idle_v(); e.outa = 3'b001; e.rf_fun = 2'b01; e.rf_rsel = 4'b1000;
    add(16'h3D00, 4'h0, e, 1'b0, idle_v());
    // ST R2 -> [0x80]
    e = idle_v(); e.mux_b = 2'd2; e.arf_fun = 2'b01; e.arf_rsel = 4'b0010;
    m = idle_v(); m.arf_outb = 2'b01; m.mem_cs = 1'b0; m.mem_wr = 1'b1;
    m.outa = 3'b010;
    add(16'h2280, 4'h0, e, 1'b1, m);
    // LDM R3 <- [0x44]
    e = idle_v(); e.mux_b = 2'd2; e.arf_fun = 2'b01; e.arf_rsel = 4'b0010;
    m = idle_v(); m.arf_outb = 2'b01; m.mem_cs = 1'b0; m.mux_a = 2'd1;
    m.rf_fun = 2'b01; m.rf_rsel = 4'b1000;
    add(16'h1C44, 4'h0, e, 1'b1, m);
    // BRA 0x12, BNE taken (Z=0), BNE not taken (Z=1), BNE taken with C/N/O set
    e = idle_v(); e.mux_b = 2'd2; e.arf_fun = 2'b01; e.arf_rsel = 4'b0001;
    add(16'h8012, 4'h8, e, 1'b0, idle_v());
    add(16'h9010, 4'b0000, e, 1'b0, idle_v());
    add(16'h9010, 4'b1000, idle_v(), 1'b0, idle_v());
    add(16'h9010, 4'b0111, e, 1'b0, idle_v());
    // Unassigned opcodes are NOPs
    add(16'hC123, 4'h0, idle_v(), 1'b0, idle_v());
    add(16'hA0FF, 4'h0, idle_v(), 1'b0, idle_v());

    // ---------------- reset ----------------
    rst        = 1'b1;
    cu_if.IR   = 16'h0000;
    cu_if.ZCNO = 4'h0;
    repeat (3) @(posedge clk);
    #2;
    chk_state("reset_state", 3'd0);
    chk_ctrl("reset_idle", idle_v());
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_ctrl("post_reset_fetch_l", fetch_v(1'b0));

    // ---------------- table ----------------
    foreach (vq[i]) run_instr(vq[i]);

    // ---------------- reset during FETCH_H ----------------
    chk_state("rst_mid_fetch_l", 3'd0);
    cu_if.IR = 16'h042A;
    @(posedge clk); #2;
    chk_state("rst_mid_fetch_h", 3'd1);
    rst = 1'b1;
    #1;
    chk_state("rst_mid_async_state", 3'd0);
    chk_ctrl("rst_mid_idle", idle_v());
    @(posedge clk); #2;
    chk_state("rst_mid_held_state", 3'd0);
    chk_ctrl("rst_mid_held_idle", idle_v());
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("reset during FETCH_H checks=%0d errors=%0d", checks, errors);
    v = vq[0];
    run_instr(v);

    // ---------------- halt ----------------
    chk_state("hlt_fetch_l", 3'd0);
    cu_if.IR = 16'hF000;
    @(posedge clk); #2;
    chk_state("hlt_fetch_h", 3'd1);
    @(posedge clk); #2;
    chk_state("hlt_exec", 3'd2);
    chk_ctrl("hlt_exec_idle", idle_v());
    e = idle_v(); e.halted = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #2;
      chk_state("halt_state", 3'd4);
      chk_ctrl("halt_ctrl", e);
    end
    $display("halt held 20 cycles checks=%0d errors=%0d", checks, errors);
    rst = 1'b1;
    #1;
    chk_state("halt_exit_state", 3'd0);
    chk_ctrl("halt_exit_idle", idle_v());
    @(negedge clk);
    rst = 1'b0;
    #1;

    // NOP after halt, then confirm the sequencer wraps to FETCH_L
    v = vq[12];
    run_instr(v);
    chk_state("final_fetch_l", 3'd0);
    chk_ctrl("final_fetch_l_ctrl", fetch_v(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
